// File: rtl/pmem_write_buffer_if.sv
// pmem_write_buffer_if: L2-side and physical-memory-side signals of the write buffer.
interface pmem_write_buffer_if;
  logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [15:0] mem_address, pmem_address;
  logic [127:0] mem_wdata, mem_rdata, pmem_wdata, pmem_rdata;
  modport slave (
    input mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    input mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_write_buffer.sv
// pmem_write_buffer: coalescing FIFO of line writebacks between L2 and physical memory.
// Define PMEM_WBUF_FWD_EN to serve read hits straight from the buffer.
module pmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  pmem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, READ_MEM, DRAIN, RESP} state_t;
  state_t state, state_n;
  logic [15:0] addr [DEPTH];
  logic [127:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head, tail, hit_idx;
  logic [PW:0] count;
  logic [127:0] rdata;
  logic hit, do_coal, do_enq, do_pop, ld_pmem;
`ifdef PMEM_WBUF_FWD_EN
  logic ld_fwd;
`endif
  // Coalescing keeps addresses unique, so at most one entry can match.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && addr[i] == bus.mem_address) begin
        hit = 1'b1;
        hit_idx = PW'(i);
      end
  end
  always_comb begin
    state_n = state;
    do_coal = 1'b0;
    do_enq = 1'b0;
    do_pop = 1'b0;
    ld_pmem = 1'b0;
`ifdef PMEM_WBUF_FWD_EN
    ld_fwd = 1'b0;
`endif
    case (state)
      IDLE:
        if (bus.mem_read) begin
`ifdef PMEM_WBUF_FWD_EN
          ld_fwd = hit;
          state_n = hit ? RESP : READ_MEM;
`else
          state_n = hit ? DRAIN : READ_MEM;
`endif
        end else if (bus.mem_write) begin
          do_coal = hit;
          do_enq = !hit && count != FULL;
          state_n = (hit || count != FULL) ? RESP : DRAIN;
        end else if (count != '0) state_n = DRAIN;
      READ_MEM: begin
        ld_pmem = bus.pmem_resp;
        state_n = bus.pmem_resp ? RESP : READ_MEM;
      end
      DRAIN: begin
        do_pop = bus.pmem_resp;
        state_n = bus.pmem_resp ? IDLE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (do_enq) begin
        valid[tail] <= 1'b1;
        tail <= tail + 1'b1;
        count <= count + 1'b1;
      end
      if (do_pop) begin
        valid[head] <= 1'b0;
        head <= head + 1'b1;
        count <= count - 1'b1;
      end
      if (ld_pmem) rdata <= bus.pmem_rdata;
`ifdef PMEM_WBUF_FWD_EN
      if (ld_fwd) rdata <= data[hit_idx];
`endif
    end
  end
  // Payload storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_coal) data[hit_idx] <= bus.mem_wdata;
    if (do_enq) begin
      addr[tail] <= bus.mem_address;
      data[tail] <= bus.mem_wdata;
    end
  end
  assign bus.mem_resp = state == RESP;
  assign bus.mem_rdata = rdata;
  assign bus.pmem_read = state == READ_MEM;
  assign bus.pmem_write = state == DRAIN;
  assign bus.pmem_address = state == READ_MEM ? bus.mem_address : state == DRAIN ? addr[head] : '0;
  assign bus.pmem_wdata = state == DRAIN ? data[head] : '0;
endmodule

// File: tb/tb_pmem_write_buffer.sv
// tb_pmem_write_buffer: directed scenarios for the write buffer, default DEPTH=4.
module tb_pmem_write_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  pmem_write_buffer_if bus();
  pmem_write_buffer #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [127:0] LA = {4{32'hAAAA_0001}};
  localparam logic [127:0] LB = {4{32'hBBBB_0002}};
  localparam logic [127:0] LC = {4{32'hCCCC_0003}};
  localparam logic [127:0] LD = {4{32'hDDDD_0004}};
  localparam logic [127:0] LE = {4{32'hEEEE_0005}};
  localparam logic [127:0] LF = {4{32'hFFFF_0006}};
  localparam logic [127:0] LG = {4{32'h1234_5678}};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // lat counts rising edges from request drive until mem_resp is seen; -1 on timeout.
  task automatic wait_resp(input int budget, output int lat, output bit saw_pread);
    lat = -1;
    saw_pread = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (bus.pmem_read) saw_pread = 1'b1;
      if (bus.mem_resp) begin
        lat = n;
        break;
      end
    end
  endtask
  task automatic wait_pmem(input int budget, input bit rd, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      ok = rd ? bus.pmem_read : bus.pmem_write;
    end
  endtask
  task automatic pmem_ack(input logic [127:0] d);
    bus.pmem_rdata = d;
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
  endtask
  task automatic set_req(input bit rd, input bit wr, input logic [15:0] a, input logic [127:0] d);
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.mem_address = a;
    bus.mem_wdata = d;
  endtask
  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: resp=%b pread=%b pwrite=%b, required 0 0 0", bus.mem_resp, bus.pmem_read, bus.pmem_write);
    end
    checks++;
    if (bus.mem_rdata !== 128'h0 || bus.pmem_wdata !== 128'h0 || bus.pmem_address !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h wdata=%h addr=%h, required all zero", bus.mem_rdata, bus.pmem_wdata, bus.pmem_address);
    end
    checks++;
    if (dut.count !== '0) begin
      failures++;
      $display("FAIL reset_count: got %0d, required 0", dut.count);
    end
    #4 rst_n = 1'b1;
  endtask
  task automatic test_write_drain();
    int lat;
    bit sp, ok;
    set_req(0, 1, 16'h1230, LA);
    wait_resp(6, lat, sp);
    set_req(0, 0, 16'h0, 128'h0);
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL write_latency: got %0d edges, required 1", lat);
    end
    wait_pmem(6, 0, ok);
    checks++;
    if (!ok || bus.pmem_address !== 16'h1230 || bus.pmem_wdata !== LA) begin
      failures++;
      $display("FAIL drain_a: seen=%b addr=%h data=%h, required 1 1230 %h", ok, bus.pmem_address, bus.pmem_wdata, LA);
    end
    pmem_ack(128'h0);
    checks++;
    if (dut.count !== '0 || bus.pmem_write !== 1'b0) begin
      failures++;
      $display("FAIL drain_pop: count=%0d pwrite=%b, required 0 0", dut.count, bus.pmem_write);
    end
  endtask
  task automatic test_coalesce();
    int lat1, lat2;
    bit sp, ok;
    set_req(0, 1, 16'h1230, LA);
    wait_resp(6, lat1, sp);
    set_req(0, 1, 16'h1230, LB);
    wait_resp(6, lat2, sp);
    set_req(0, 0, 16'h0, 128'h0);
    checks++;
    if (lat1 != 1 || lat2 != 2 || int'(dut.count) != 1) begin
      failures++;
      $display("FAIL coalesce_accept: lat1=%0d lat2=%0d count=%0d, required 1 2 1", lat1, lat2, dut.count);
    end
    wait_pmem(6, 0, ok);
    checks++;
    if (!ok || bus.pmem_address !== 16'h1230 || bus.pmem_wdata !== LB) begin
      failures++;
      $display("FAIL coalesce_drain: seen=%b addr=%h data=%h, required 1 1230 %h", ok, bus.pmem_address, bus.pmem_wdata, LB);
    end
    pmem_ack(128'h0);
    wait_pmem(5, 0, ok);
    checks++;
    if (ok || dut.count !== '0) begin
      failures++;
      $display("FAIL coalesce_single: extra_drain=%b count=%0d, required 0 0", ok, dut.count);
    end
  endtask
  task automatic test_full();
    int lat;
    bit sp, ok, early;
    logic [15:0] exp_a [5];
    logic [127:0] exp_d [5];
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = 16'h4000 + 16'(i * 16);
      exp_d[i] = {4{32'(32'h0400_0000 + i)}};
    end
    exp_a[4] = 16'h4440;
    exp_d[4] = LE;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, exp_a[i], exp_d[i]);
      wait_resp(6, lat, sp);
    end
    set_req(0, 1, exp_a[4], exp_d[4]);
    early = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.mem_resp) early = 1'b1;
    end
    checks++;
    if (early || int'(dut.count) != 4 || !bus.pmem_write || bus.pmem_address !== 16'h4000) begin
      failures++;
      $display("FAIL full_stall: early_resp=%b count=%0d pwrite=%b addr=%h, required 0 4 1 4000", early, dut.count, bus.pmem_write, bus.pmem_address);
    end
    pmem_ack(128'h0);
    wait_resp(4, lat, sp);
    set_req(0, 0, 16'h0, 128'h0);
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL full_accept: latency after pop %0d, required 1", lat);
    end
    for (int i = 1; i < 5; i++) begin
      wait_pmem(6, 0, ok);
      checks++;
      if (!ok || bus.pmem_address !== exp_a[i] || bus.pmem_wdata !== exp_d[i]) begin
        failures++;
        $display("FAIL full_order%0d: seen=%b addr=%h data=%h, required 1 %h %h", i, ok, bus.pmem_address, bus.pmem_wdata, exp_a[i], exp_d[i]);
      end
      pmem_ack(128'h0);
    end
  endtask
  task automatic test_read_hit();
    int lat;
    bit sp, ok;
    set_req(0, 1, 16'h2000, LC);
    wait_resp(6, lat, sp);
    set_req(1, 0, 16'h2000, 128'h0);
`ifdef PMEM_WBUF_FWD_EN
    wait_resp(6, lat, sp);
    checks++;
    if (lat != 2 || sp || bus.mem_rdata !== LC) begin
      failures++;
      $display("FAIL read_fwd: lat=%0d pread=%b rdata=%h, required 2 0 %h", lat, sp, bus.mem_rdata, LC);
    end
    set_req(0, 0, 16'h0, 128'h0);
    wait_pmem(6, 0, ok);
    pmem_ack(128'h0);
`else
    wait_pmem(6, 0, ok);
    checks++;
    if (!ok || bus.pmem_read || bus.pmem_address !== 16'h2000 || bus.pmem_wdata !== LC) begin
      failures++;
      $display("FAIL read_hit_drain: seen=%b pread=%b addr=%h data=%h, required 1 0 2000 %h", ok, bus.pmem_read, bus.pmem_address, bus.pmem_wdata, LC);
    end
    pmem_ack(128'h0);
    wait_pmem(6, 1, ok);
    checks++;
    if (!ok || bus.pmem_write || bus.pmem_address !== 16'h2000) begin
      failures++;
      $display("FAIL read_hit_fetch: seen=%b pwrite=%b addr=%h, required 1 0 2000", ok, bus.pmem_write, bus.pmem_address);
    end
    pmem_ack(LF);
    checks++;
    if (!bus.mem_resp || bus.mem_rdata !== LF) begin
      failures++;
      $display("FAIL read_hit_data: resp=%b rdata=%h, required 1 %h", bus.mem_resp, bus.mem_rdata, LF);
    end
    set_req(0, 0, 16'h0, 128'h0);
    tick();
`endif
  endtask
  task automatic test_read_miss();
    bit ok, bad;
    int pulses;
    set_req(1, 0, 16'h3000, 128'h0);
    wait_pmem(4, 1, ok);
    bad = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!bus.pmem_read || bus.pmem_write || bus.mem_resp || bus.pmem_address !== 16'h3000) bad = 1'b1;
    end
    checks++;
    if (!ok || bad) begin
      failures++;
      $display("FAIL miss_wait: pread_seen=%b unstable=%b, required 1 0", ok, bad);
    end
    pmem_ack(LD);
    checks++;
    if (!bus.mem_resp || bus.mem_rdata !== LD) begin
      failures++;
      $display("FAIL miss_data: resp=%b rdata=%h, required 1 %h", bus.mem_resp, bus.mem_rdata, LD);
    end
    pulses = int'(bus.mem_resp);
    set_req(0, 0, 16'h0, 128'h0);
    for (int n = 0; n < 3; n++) begin
      tick();
      pulses += int'(bus.mem_resp);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL miss_pulse: %0d resp cycles, required 1", pulses);
    end
  endtask
  task automatic test_reset_mid_drain();
    int lat;
    bit sp, ok;
    set_req(0, 1, 16'h5000, LG);
    wait_resp(6, lat, sp);
    set_req(0, 0, 16'h0, 128'h0);
    wait_pmem(6, 0, ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || bus.pmem_write !== 1'b0 || dut.count !== '0) begin
      failures++;
      $display("FAIL reset_drain: drain_seen=%b pwrite=%b count=%0d, required 1 0 0", ok, bus.pmem_write, dut.count);
    end
    #2 rst_n = 1'b1;
    set_req(1, 0, 16'h5000, 128'h0);
    wait_pmem(4, 1, ok);
    checks++;
    if (!ok || bus.pmem_address !== 16'h5000) begin
      failures++;
      $display("FAIL reset_read: pread_seen=%b addr=%h, required 1 5000", ok, bus.pmem_address);
    end
    pmem_ack(LF);
    set_req(0, 0, 16'h0, 128'h0);
    tick();
  endtask
  initial begin
    set_req(0, 0, 16'h0, 128'h0);
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = 128'h0;
    test_reset();
    test_write_drain();
    test_coalesce();
    test_full();
    test_read_hit();
    test_read_miss();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
